alu_host: RTL

ALU_HOST -- requirements
Module: alu_host

---
 rtl/alu_host_if.sv | 29 ++
 rtl/alu_host.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_host_if.sv
// alu_host_if: client request/response bundle plus the 8-bit BEGIN/END ALU bus.
// Latency: none, wiring only.
// Backpressure: req_valid/req_ready on requests, rsp_valid/rsp_ready on responses.
interface alu_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        BEGIN;
  logic [1:0]  op_code;
  logic [7:0]  inbus;
  logic        END;
  logic [7:0]  outbus;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, END, outbus,
    output req_ready, rsp_valid, rsp_data, rsp_err, BEGIN, op_code, inbus
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, END, outbus,
    input  req_ready, rsp_valid, rsp_data, rsp_err, BEGIN, op_code, inbus
  );
endinterface

// File: rtl/alu_host.sv
// alu_host: drives add/sub/mul/div over the byte-wide BEGIN/END ALU bus; ALU_HOST_TIMEOUT_EN adds a WAIT_END abort.
// Latency: accept->rsp_valid 4 (add/sub), 5 (mul), 6 (div) cycles, plus any END wait.
// Backpressure: req_ready only in IDLE; response held until rsp_ready, no new request accepted before.
module alu_host #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  alu_host_if.slave  bus
);

  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, WAIT_END, CAPT1, RESP} state_t;

  state_t      state;
  logic [7:0]  a_lo;
  logic [7:0]  b_q;
  logic [7:0]  byte0;
  logic        begin_q;
  logic [1:0]  op_q;
  logic [7:0]  inbus_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("alu_host: TIMEOUT_CYCLES must be 1..255");
  end

`ifdef ALU_HOST_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic       rsp_err_q;
  logic [7:0] to_cnt;
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      a_lo        <= 8'h00;
      b_q         <= 8'h00;
      byte0       <= 8'h00;
      begin_q     <= 1'b0;
      op_q        <= 2'b00;
      inbus_q     <= 8'h00;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
`ifdef ALU_HOST_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      to_cnt      <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            // First byte goes out straight from the request bus so BEGIN lands in SEND0.
            a_lo        <= bus.req_a[7:0];
            b_q         <= bus.req_b;
            op_q        <= bus.req_op;
            begin_q     <= 1'b1;
            inbus_q     <= (bus.req_op == OP_DIV) ? bus.req_a[15:8] : bus.req_a[7:0];
            req_ready_q <= 1'b0;
            state       <= SEND0;
          end
        end
        SEND0: begin
          begin_q <= 1'b0;
          inbus_q <= (op_q == OP_DIV) ? a_lo : b_q;
          state   <= SEND1;
        end
        SEND1: begin
`ifdef ALU_HOST_TIMEOUT_EN
          to_cnt <= 8'h00;
`endif
          if (op_q == OP_DIV) begin
            inbus_q <= b_q;
            state   <= SEND2;
          end else begin
            state   <= WAIT_END;
          end
        end
        SEND2: state <= WAIT_END;
        WAIT_END: begin
          if (bus.END) begin
            byte0 <= bus.outbus;
            if (op_q[1]) begin
              state <= CAPT1;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= {8'h00, bus.outbus};
              state       <= RESP;
            end
          end
`ifdef ALU_HOST_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= 16'hFFFF;
            rsp_err_q   <= 1'b1;
            state       <= RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        CAPT1: begin
          // mul: {hi, lo}; div: {remainder, quotient} -- both arrive in that order.
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= {byte0, bus.outbus};
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
`ifdef ALU_HOST_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.BEGIN     = begin_q;
  assign bus.op_code   = op_q;
  assign bus.inbus     = inbus_q;

endmodule
